// File: rtl/shift_seq_if.sv
// Request/result bundle between the pipeline and the multi-cycle shift sequencer.
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both 1. The requester holds op/a/shamt stable while
// in_valid is 1 and in_ready is 0. result stays stable while out_valid is 1
// and out_ready is 0.
interface shift_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  // Pipeline-control side: issues requests and consumes results.
  modport master (
    output in_valid, op, a, shamt, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, op, a, shamt, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: SLL/SRL/SRA/ROR on a 32-bit operand, moving at
// most STEP bits per cycle through a narrow shifter instead of a barrel shifter.
// All outputs decode registered state only; flush and reset force IDLE.
module shift_seq #(
  parameter int STEP = 4  // bits per cycle: 1, 2, 4, 8 or 16
) (
  input  logic        clk,
  input  logic        rst,        // synchronous, active low
  shift_seq_if.slave  bus,
  output logic [1:0]  dbg_state   // current FSM state for observation
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rem_q, rem_d;
  logic [1:0]  opr_q, opr_d;
  logic [4:0]  step_amt;
  logic [4:0]  rem_next;
  logic [31:0] step_res;

  // Bits to move this cycle: min(STEP, rem); rem never underflows.
  always_comb begin
    step_amt = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
    rem_next = rem_q - step_amt;
  end

  // Narrow shifter: one constant-distance shift per legal amount 1..STEP,
  // selected by step_amt; amount 0 passes acc through.
  always_comb begin
    step_res = acc_q;
    for (int i = 1; i <= STEP; i++) begin
      if (step_amt == 5'(i)) begin
        case (opr_q)
          2'b00:   step_res = acc_q << i;
          2'b01:   step_res = acc_q >> i;
          2'b10:   step_res = 32'($signed(acc_q) >>> i);
          default: step_res = (acc_q >> i) | (acc_q << (32 - i));
        endcase
      end
    end
  end

  // Next-state and datapath updates; flush outranks accept and handshake.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opr_d    = opr_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            acc_d = bus.a;
            rem_d = bus.shamt;
            opr_d = bus.op;
            if (bus.shamt == 5'd0) begin
              state_d  = DONE;
              result_d = bus.a;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_d = step_res;
          rem_d = rem_next;
          if (rem_next == 5'd0) begin
            state_d  = DONE;
            result_d = step_res;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= 32'h0;
      rem_q    <= 5'd0;
      opr_q    <= 2'b00;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opr_q    <= opr_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: vector table and corner sequences on a STEP=4 instance,
// plus random operations on STEP=1/2/8/16 instances against a bitwise model.
module tb_shift_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  shift_seq_if bus();
  logic [1:0] dbg_state;

  shift_seq #(.STEP(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  // ---------------- model / checking helpers ----------------
  function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                            input logic [31:0] a, input int n);
    logic [31:0] v;
    v = a;
    for (int i = 0; i < n; i++) begin
      case (op)
        2'b00:   v = {v[30:0], 1'b0};
        2'b01:   v = {1'b0, v[31:1]};
        2'b10:   v = {v[31], v[31:1]};
        default: v = {v[0], v[31:1]};
      endcase
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (STEP=4 instance) ----------------
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] shamt, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op = op; bus.a = a; bus.shamt = shamt; bus.in_valid = 1'b1;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 60) begin
      lat++;
      if (bus.out_valid) break;
      @(posedge clk); #1;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, bus.result, exp_q.pop_front());
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    check({name, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
  endtask

  // ---------------- STEP sweep instances ----------------
  logic sweep_go = 1'b0;
  int   sweep_done = 0;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    shift_seq_if sb();
    logic [1:0] sdbg;
    logic [31:0] sexp_q[$];

    shift_seq #(.STEP(S)) u_dut (
      .clk(clk), .rst(rst), .bus(sb), .dbg_state(sdbg)
    );

    initial begin
      logic [1:0]  op;
      logic [31:0] a;
      int          sh;
      int          lat;
      sb.in_valid = 1'b0; sb.flush = 1'b0; sb.out_ready = 1'b0;
      sb.op = 2'b00; sb.a = 32'h0; sb.shamt = 5'd0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        sh = (i == 0) ? 0 : (i == 1) ? 31 : int'($urandom_range(1, 30));
        check($sformatf("sweep S%0d #%0d in_ready", S, i), 32'(sb.in_ready), 32'd1);
        sb.op = op; sb.a = a; sb.shamt = 5'(sh); sb.in_valid = 1'b1;
        sexp_q.push_back(ref_shift(op, a, sh));
        @(posedge clk); #1;
        sb.in_valid = 1'b0;
        lat = 0;
        while (lat < 60) begin
          lat++;
          if (sb.out_valid) break;
          @(posedge clk); #1;
        end
        check($sformatf("sweep S%0d #%0d latency", S, i), 32'(lat),
              32'(1 + (sh + S - 1) / S));
        check($sformatf("sweep S%0d #%0d result op%0d sh%0d", S, i, op, sh),
              sb.result, sexp_q.pop_front());
        sb.out_ready = 1'b1;
        @(posedge clk); #1;
        sb.out_ready = 1'b0;
      end
      check($sformatf("sweep S%0d idle state", S), 32'(sdbg), 32'd0);
      sweep_done++;
    end
  end

  // ---------------- main sequence ----------------
  vec_t vecs[$];

  initial begin
    int seen;
    vecs.push_back('{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9});
    vecs.push_back('{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9});
    vecs.push_back('{2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1});
    vecs.push_back('{2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F, 2});
    vecs.push_back('{2'b10, 32'h7FFF_FFF0, 5'd8,  32'h007F_FFFF, 3});
    vecs.push_back('{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1});
    vecs.push_back('{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9});
    vecs.push_back('{2'b11, 32'h0000_0001, 5'd5,  32'h0800_0000, 3});
    vecs.push_back('{2'b10, 32'hC000_0000, 5'd3,  32'hF800_0000, 2});
    vecs.push_back('{2'b10, 32'h8000_0000, 5'd0,  32'h8000_0000, 1});
    vecs.push_back('{2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780, 2});

    // Reset held for two cycles with a request pending.
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFF_FFFF; bus.shamt = 5'd3;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset result", bus.result, 32'h0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-reset no accept", 32'(bus.busy), 32'd0);

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].shamt,
             vecs[i].exp_res, vecs[i].exp_lat);
      consume($sformatf("vec%0d", i));
    end

    // Backpressure: result held, extra requests ignored.
    run_op("bp", 2'b00, 32'h1, 5'd5, 32'h20, 3);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.op = 2'($urandom_range(0, 3));
      bus.a = $urandom; bus.shamt = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      check($sformatf("bp hold%0d result", i), bus.result, 32'h20);
      check($sformatf("bp hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp hold%0d in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    consume("bp");
    @(posedge clk); #1;
    check("bp no phantom accept", 32'(bus.busy), 32'd0);
    check("bp result kept", bus.result, 32'h20);

    // Flush on the second SHIFT cycle.
    bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.shamt = 5'd20; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("flush first shift state", 32'(dbg_state), 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush in_ready", 32'(bus.in_ready), 32'd1);
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("flush out_valid never", 32'(seen), 32'd0);
    run_op("after flush", 2'b00, 32'h3, 5'd1, 32'h6, 2);
    consume("after flush");

    // Reset in the middle of a SHIFT.
    bus.op = 2'b10; bus.a = 32'h8000_0000; bus.shamt = 5'd31; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset pre busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset result", bus.result, 32'h0);
    check("midreset state", 32'(dbg_state), 32'd0);
    run_op("after midreset", 2'b01, 32'hF000_0000, 5'd12, 32'h000F_0000, 4);
    consume("after midreset");

    // STEP sweep on the other instances.
    sweep_go = 1'b1;
    for (int c = 0; c < 5000 && sweep_done < 4; c++) @(posedge clk);
    #1;
    check("sweep completed", 32'(sweep_done), 32'd4);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the EX stage of the pipelined CPU. It performs SLL/SRL/SRA/ROR on a 32-bit operand by stepping a narrow shifter at most STEP bits per cycle, instead of using a full 32-bit barrel shifter. It exposes a valid/ready request port toward the pipeline control and a valid/ready result port back to EX. `busy` feeds the hazard unit as a stall source.

## Interface
- STEP, default 4, maximum bits shifted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- a  in  32  operand.
- shamt  in  5  shift amount, 0..31.
- flush  in  1  abort the current operation (pipeline flush).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  32  shifted value.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: iterating.
  - DONE: out_valid=1, result held.
- Accept happens on an edge where state==IDLE, in_valid=1 and flush=0.
  - acc<=a, rem<=shamt, opr<=op are latched.
  - Next state is DONE if shamt==0, else SHIFT.
- SHIFT, each cycle:
  - s = min(STEP, rem); acc <= acc shifted by s per opr; rem <= rem - s.
  - When rem - s == 0, next state is DONE.
- Shift rules:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with the current acc[31]. The sign is preserved across steps, so a negative operand yields all-ones fill.
  - ROR: bits shifted out at bit 0 re-enter at bit 31.
- Width rules:
  - All arithmetic is 32-bit.
  - rem is 5 bits and never underflows.
  - shamt=0 returns a unchanged for every op.
- DONE: when out_valid & out_ready, next state is IDLE. result keeps its value after leaving DONE until the next write.
- A new request cannot be accepted in the same cycle a result is consumed. in_ready rises the cycle after the handshake.
- in_valid while not IDLE is ignored. Requesters must hold the request until in_ready.
- flush=1 on any edge forces the next state to IDLE and clears out_valid. acc and result are not required to clear. flush beats accept and the output handshake in the same cycle.
- Reset (rst=0) overrides everything, including mid-SHIFT and DONE:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - result=32'h0, acc=0, rem=0.

## Timing
- Accept at edge k gives out_valid=1 from edge k+1+ceil(shamt/STEP).
  - With STEP=4: shamt 0 gives latency 1; shamt 4 gives 2; shamt 31 gives 9.
- result is registered. It is valid and stable whenever out_valid=1 and does not change while out_valid=1 && out_ready=0.
- in_ready and busy are decoded from registered state only. There is no combinational path from in_valid, out_ready or flush to any output.
- Throughput: one operation per (latency + 1) cycles at best, since IDLE costs one cycle between operations.
- The per-step shifter handles 0..STEP bits. No 32-bit variable shifter may exist in the datapath.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, result=0; no request accepted.
- SRA, STEP=4: a=0x8000_0000, shamt=31 -> out_valid rises exactly 9 cycles after accept with result=0xFFFF_FFFF; SRL with the same inputs gives 0x0000_0001.
- shamt=0 and ROR: SLL a=0x1234_5678, shamt=0 -> result=0x1234_5678 one cycle after accept; ROR a=0x0000_00F1, shamt=4 -> result=0x1000_000F after 2 cycles.
- Backpressure: SLL a=1, shamt=5, out_ready=0 for 6 cycles -> result=0x20 stable, out_valid=1, in_ready=0; in_valid pulses are ignored; handshake occurs then in_ready=1 the next cycle.
- Flush mid-shift: SRL a=0xFFFF_FFFF, shamt=20, flush=1 on 2nd SHIFT cycle -> next cycle IDLE, out_valid never asserts; a following SLL a=3, shamt=1 returns 0x6 with normal latency.
- Reset mid-operation and STEP sweep: rst=0 during SHIFT -> all outputs return to reset values. Repeat random a/op/shamt for STEP=1,2,8,16 against a reference model and check latency 1+ceil(shamt/STEP).
